// File: rtl/clock_divider_pkg.sv
// Shared widths, reset defaults and per-channel configuration record for the divider bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_divider_pkg;

    localparam int CNT_W_DEF             = 16;
    localparam int CNT_W_MAX             = 32;
    localparam int RESET_HALF_PERIOD_DEF = 25000;

    // Fields sized for the widest supported counter; users cast to their CNT_W.
    typedef struct packed {
        logic [CNT_W_MAX-1:0] half_period;
        logic [CNT_W_MAX-1:0] phase;
    } chan_cfg_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: toggles outputClock every H enabled edges, ticks on each rise.
// Latency: config/restart take effect on the next edge; new H adopted at the next toggle.
// Backpressure: none; enable low freezes count and level, tick forced low.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int CNT_W             = CNT_W_DEF,
    parameter int RESET_HALF_PERIOD = RESET_HALF_PERIOD_DEF
) (
    input  logic      inputClock,
    input  logic      reset,
    input  logic      enable,
    input  logic      load,
    input  logic      sync_restart,
    input  chan_cfg_t load_cfg,
    output logic      outputClock,
    output logic      tick
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_HP  = CNT_W'(RESET_HALF_PERIOD);

    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pend_nxt;
    logic [CNT_W-1:0] phase_nxt;

    assign pend_nxt  = load ? CNT_W'(load_cfg.half_period) : pend_q;
    assign phase_nxt = load ? CNT_W'(load_cfg.phase)       : phase_q;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c,
                                                    input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] lim;
        lim = h - ONE;
        if (h == '0) return '0;
        return (c > lim) ? lim : c;
    endfunction

    always_ff @(posedge inputClock or posedge reset) begin
        if (reset) begin
            half_q      <= RST_HP;
            pend_q      <= RST_HP;
            phase_q     <= '0;
            cnt_q       <= '0;
            outputClock <= 1'b0;
            tick        <= 1'b0;
        end else begin
            pend_q  <= pend_nxt;
            phase_q <= phase_nxt;
            if (sync_restart) begin
                half_q      <= pend_nxt;
                cnt_q       <= clamp_cnt(phase_nxt, pend_nxt);
                outputClock <= 1'b0;
                tick        <= 1'b0;
            end else if (half_q == '0) begin
                half_q      <= pend_nxt;
                cnt_q       <= '0;
                outputClock <= 1'b0;
                tick        <= 1'b0;
            end else if (!enable) begin
                // Idle channel may adopt a new H at once; keep C inside the new range.
                half_q <= pend_nxt;
                cnt_q  <= clamp_cnt(cnt_q, pend_nxt);
                tick   <= 1'b0;
            end else if (cnt_q == half_q - ONE) begin
                half_q      <= pend_nxt;
                cnt_q       <= '0;
                outputClock <= ~outputClock;
                tick        <= ~outputClock;
            end else begin
                cnt_q <= cnt_q + ONE;
                tick  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS independent clock dividers with per-channel load and shared realign.
// Latency: one cycle from load/sync_restart strobe to channel state update.
// Backpressure: none; out-of-range load_channel is dropped.
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int CHANNELS          = 4,
    parameter int CNT_W             = CNT_W_DEF,
    parameter int RESET_HALF_PERIOD = RESET_HALF_PERIOD_DEF
) (
    input  logic                        inputClock,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         enable,
    input  logic                        load,
    input  logic [idx_w(CHANNELS)-1:0]  load_channel,
    input  logic [CNT_W-1:0]            load_half_period,
    input  logic [CNT_W-1:0]            load_phase,
    input  logic                        sync_restart,
    output logic [CHANNELS-1:0]         outputClock,
    output logic [CHANNELS-1:0]         tick
);

    localparam int LCW = idx_w(CHANNELS);

    chan_cfg_t load_cfg;

    always_comb begin
        load_cfg             = '0;
        load_cfg.half_period = CNT_W_MAX'(load_half_period);
        load_cfg.phase       = CNT_W_MAX'(load_phase);
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic ch_load;
            // Indices >= CHANNELS never match any instance, so they are ignored.
            assign ch_load = load && (load_channel == LCW'(i));

            clock_divider_channel #(
                .CNT_W             (CNT_W),
                .RESET_HALF_PERIOD (RESET_HALF_PERIOD)
            ) u_ch (
                .inputClock   (inputClock),
                .reset        (reset),
                .enable       (enable[i]),
                .load         (ch_load),
                .sync_restart (sync_restart),
                .load_cfg     (load_cfg),
                .outputClock  (outputClock[i]),
                .tick         (tick[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: expected rise cycles are queued per scenario
// and matched against observed ticks and outputClock rises.
module tb_clock_divider_bank;

    localparam int CH = 4;
    localparam int HP = 4;

    logic          inputClock = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic          load;
    logic [1:0]    load_channel;
    logic [15:0]   load_half_period;
    logic [15:0]   load_phase;
    logic          sync_restart;
    logic [CH-1:0] outputClock;
    logic [CH-1:0] tick;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int exp_q[$];
    int tick_q[$];
    int rise_q[$];
    logic [CH-1:0] prev_out = '0;
    logic [CH-1:0] out_hist  [0:511];
    logic [CH-1:0] tick_hist [0:511];

    clock_divider_bank #(
        .CHANNELS          (CH),
        .CNT_W             (16),
        .RESET_HALF_PERIOD (HP)
    ) dut (
        .inputClock       (inputClock),
        .reset            (reset),
        .enable           (enable),
        .load             (load),
        .load_channel     (load_channel),
        .load_half_period (load_half_period),
        .load_phase       (load_phase),
        .sync_restart     (sync_restart),
        .outputClock      (outputClock),
        .tick             (tick)
    );

    always #5 inputClock = ~inputClock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one edge, sample 1ns later, log tick and rise events as cyc*16+ch.
    task automatic step();
        @(posedge inputClock);
        #1;
        cyc++;
        out_hist[cyc]  = outputClock;
        tick_hist[cyc] = tick;
        for (int ch = 0; ch < CH; ch++) begin
            if (tick[ch]) tick_q.push_back(cyc * 16 + ch);
            if (outputClock[ch] && !prev_out[ch]) rise_q.push_back(cyc * 16 + ch);
        end
        prev_out = outputClock;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_rises(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back((first + k * period) * 16 + ch);
    endtask

    task automatic clear_events();
        tick_q.delete();
        rise_q.delete();
        exp_q.delete();
    endtask

    task automatic do_load(input int ch, input int hp, input int ph);
        load             = 1'b1;
        load_channel     = 2'(ch);
        load_half_period = 16'(hp);
        load_phase       = 16'(ph);
    endtask

    task automatic test_reset();
        int r0, e, t, r;
        reset = 1'b1; enable = '0; load = 1'b0; load_channel = '0;
        load_half_period = '0; load_phase = '0; sync_restart = 1'b0;
        repeat (3) step();
        cmp_cnt++;
        if (outputClock !== 4'h0 || tick !== 4'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: clk=%b tick=%b, want 0000/0000", outputClock, tick);
        end
        clear_events();
        enable = 4'hF;
        reset  = 1'b0;
        r0     = cyc;
        for (int ch = 0; ch < CH; ch++) push_rises(ch, r0 + 4, 8, 3);
        step_to(r0 + 23);
        cmp_cnt++;
        if (out_hist[r0 + 3] !== 4'h0 || out_hist[r0 + 4] !== 4'hF ||
            out_hist[r0 + 7] !== 4'hF || out_hist[r0 + 8] !== 4'h0) begin
            err_cnt++;
            $display("FAIL reset_levels: %b %b %b %b, want 0000 1111 1111 0000",
                     out_hist[r0 + 3], out_hist[r0 + 4], out_hist[r0 + 7], out_hist[r0 + 8]);
        end
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL reset_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL reset_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    task automatic test_load_change();
        int r0, e, t, r;
        r0 = cyc - 23;
        step_to(r0 + 25);
        do_load(1, 3, 0);
        step();
        load = 1'b0;
        push_rises(0, r0 + 28, 8, 3);
        push_rises(2, r0 + 28, 8, 3);
        push_rises(3, r0 + 28, 8, 3);
        push_rises(1, r0 + 28, 6, 3);
        step_to(r0 + 45);
        cmp_cnt++;
        if (out_hist[r0 + 30][1] !== 1'b1 || out_hist[r0 + 31][1] !== 1'b0 ||
            out_hist[r0 + 33][1] !== 1'b0 || out_hist[r0 + 31][0] !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_levels: ch1 %b%b%b ch0 %b, want 100 1",
                     out_hist[r0 + 30][1], out_hist[r0 + 31][1], out_hist[r0 + 33][1], out_hist[r0 + 31][0]);
        end
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL load_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL load_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    task automatic test_phase_restart();
        int a0, e, t, r;
        a0 = cyc;
        do_load(0, 4, 0);
        step();
        do_load(1, 4, 2);
        sync_restart = 1'b1;
        step();
        load = 1'b0;
        sync_restart = 1'b0;
        cmp_cnt++;
        if (out_hist[a0 + 2] !== 4'h0 || tick_hist[a0 + 2] !== 4'h0) begin
            err_cnt++;
            $display("FAIL phase_restart_low: clk=%b tick=%b, want 0000/0000", out_hist[a0 + 2], tick_hist[a0 + 2]);
        end
        clear_events();
        push_rises(1, a0 + 4, 8, 3);
        push_rises(0, a0 + 6, 8, 3);
        push_rises(2, a0 + 6, 8, 3);
        push_rises(3, a0 + 6, 8, 3);
        step_to(a0 + 23);
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL phase_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL phase_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    task automatic test_enable_freeze();
        int a0, e, t, r;
        a0 = cyc - 23;
        enable = 4'b1011;
        repeat (5) step();
        enable = 4'hF;
        for (int k = a0 + 24; k <= a0 + 28; k++) begin
            cmp_cnt++;
            if (out_hist[k][2] !== 1'b1 || tick_hist[k][2] !== 1'b0) begin
                err_cnt++;
                $display("FAIL enable_frozen: cyc%0d clk=%b tick=%b, want 1/0", k, out_hist[k][2], tick_hist[k][2]);
            end
        end
        push_rises(0, a0 + 30, 8, 2);
        push_rises(3, a0 + 30, 8, 2);
        push_rises(1, a0 + 28, 8, 3);
        push_rises(2, a0 + 35, 8, 2);
        step_to(a0 + 44);
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL enable_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL enable_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    task automatic test_channel_off();
        int b0, e, t, r, bad_clk, bad_tick;
        b0 = cyc;
        do_load(3, 0, 0);
        step();
        load = 1'b0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        cmp_cnt++;
        if (out_hist[b0 + 2] !== 4'h0) begin
            err_cnt++;
            $display("FAIL off_restart_low: clk=%b, want 0000", out_hist[b0 + 2]);
        end
        clear_events();
        push_rises(1, b0 + 4, 8, 4);
        push_rises(0, b0 + 6, 8, 4);
        push_rises(2, b0 + 6, 8, 4);
        step_to(b0 + 30);
        bad_clk = 0;
        bad_tick = 0;
        for (int k = b0 + 2; k <= b0 + 30; k++) begin
            if (out_hist[k][3] !== 1'b0) bad_clk++;
            if (tick_hist[k][3] !== 1'b0) bad_tick++;
        end
        cmp_cnt++;
        if (bad_clk != 0 || bad_tick != 0) begin
            err_cnt++;
            $display("FAIL off_ch3_quiet: %0d clk-high and %0d tick-high cycles, want 0/0", bad_clk, bad_tick);
        end
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL off_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL off_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    task automatic test_async_reset();
        int c0, e, t, r;
        c0 = cyc;
        cmp_cnt++;
        if (out_hist[c0] !== 4'b0111) begin
            err_cnt++;
            $display("FAIL areset_pre: clk=%b, want 0111", out_hist[c0]);
        end
        do_load(2, 7, 1);
        sync_restart = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if (outputClock !== 4'h0 || tick !== 4'h0) begin
            err_cnt++;
            $display("FAIL areset_immediate: clk=%b tick=%b, want 0000/0000", outputClock, tick);
        end
        load = 1'b0;
        sync_restart = 1'b0;
        step();
        step();
        cmp_cnt++;
        if (out_hist[c0 + 2] !== 4'h0) begin
            err_cnt++;
            $display("FAIL areset_held: clk=%b, want 0000", out_hist[c0 + 2]);
        end
        reset = 1'b0;
        clear_events();
        for (int ch = 0; ch < CH; ch++) push_rises(ch, c0 + 6, 8, 3);
        step_to(c0 + 23);
        exp_q.sort();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            r = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            cmp_cnt++;
            if (t !== e || r !== e) begin
                err_cnt++;
                $display("FAIL areset_rise: tick key %0d rise key %0d, want ch%0d cyc%0d", t, r, e % 16, e / 16);
            end
        end
        cmp_cnt++;
        if (tick_q.size() + rise_q.size() != 0) begin
            err_cnt++;
            $display("FAIL areset_extra: %0d stray events, want 0", tick_q.size() + rise_q.size());
        end
        clear_events();
    endtask

    initial begin
        test_reset();
        test_load_change();
        test_phase_restart();
        test_enable_freeze();
        test_channel_off();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
